// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: FSM encoding, owner ids, latency counter width.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_AUX = 1'b1;

   localparam int unsigned LAT_W = 3;

   // Ack vector {aux, cpu} for the port that owns the current transaction.
   function automatic logic [1:0] own_ack(input logic own);
      own_ack = (own == OWN_AUX) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request picker (bit0 = CPU, bit1 = AUX) with last-grant tracking.
// Define MEM_ARB_FIXED_PRIO_EN to give the CPU fixed priority on simultaneous requests.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt_c
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   logic unused_arb;
   assign unused_arb = ^{clk, reset, upd};

   always_comb begin
      gnt_c = 2'b00;
      if (req[0])
         gnt_c = 2'b01;
      else if (req[1])
         gnt_c = 2'b10;
   end
`else
   logic last_gnt;

   // Starts at AUX so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (reset)
         last_gnt <= OWN_AUX;
      else if (upd)
         last_gnt <= gnt_c[1];
   end

   always_comb begin
      gnt_c = 2'b00;
      case (req)
         2'b01:   gnt_c = 2'b01;
         2'b10:   gnt_c = 2'b10;
         2'b11:   gnt_c = (last_gnt == OWN_AUX) ? 2'b01 : 2'b10;
         default: gnt_c = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and AUX accesses to the single-port unified memory with fixed read latency.
// Arbitration is round-robin unless MEM_ARB_FIXED_PRIO_EN is defined (CPU fixed priority).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [1:0]        state, state_nx;
   logic              own, own_nx;
   logic              we_lat, we_lat_nx;
   logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
   logic              mem_en_nx, mem_we_nx, cpu_ack_nx, aux_ack_nx;
   logic [ADDR_W-1:0] mem_addr_nx;
   logic [DATA_W-1:0] mem_wdata_nx, rdata_nx;
   logic [1:0]        gnt_c;
   logic              grant_c;

   assign grant_c = (state == ST_IDLE) && (gnt_c != 2'b00);

   rr_arb2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({aux_req, cpu_req}),
      .upd   (grant_c),
      .gnt_c (gnt_c)
   );

   // mem_addr/mem_wdata double as the latched request, so they stay stable until the next grant.
   always_comb begin
      state_nx     = state;
      own_nx       = own;
      we_lat_nx    = we_lat;
      lat_cnt_nx   = lat_cnt;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      rdata_nx     = rdata;
      mem_en_nx    = 1'b0;
      mem_we_nx    = 1'b0;
      cpu_ack_nx   = 1'b0;
      aux_ack_nx   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (grant_c) begin
               own_nx       = gnt_c[1] ? OWN_AUX : OWN_CPU;
               we_lat_nx    = gnt_c[1] ? aux_we    : cpu_we;
               mem_addr_nx  = gnt_c[1] ? aux_addr  : cpu_addr;
               mem_wdata_nx = gnt_c[1] ? aux_wdata : cpu_wdata;
               mem_en_nx    = 1'b1;
               mem_we_nx    = we_lat_nx;
               state_nx     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (we_lat) begin
               {aux_ack_nx, cpu_ack_nx} = own_ack(own);
               state_nx                 = ST_RESP;
            end else begin
               lat_cnt_nx = LAT_W'(MEM_LAT - 1);
               state_nx   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (lat_cnt == '0) begin
               rdata_nx                 = mem_rdata;
               {aux_ack_nx, cpu_ack_nx} = own_ack(own);
               state_nx                 = ST_RESP;
            end else begin
               lat_cnt_nx = lat_cnt - LAT_W'(1);
            end
         end
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         own       <= OWN_CPU;
         we_lat    <= 1'b0;
         lat_cnt   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         cpu_ack   <= 1'b0;
         aux_ack   <= 1'b0;
      end else begin
         state     <= state_nx;
         own       <= own_nx;
         we_lat    <= we_lat_nx;
         lat_cnt   <= lat_cnt_nx;
         mem_en    <= mem_en_nx;
         mem_we    <= mem_we_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         rdata     <= rdata_nx;
         cpu_ack   <= cpu_ack_nx;
         aux_ack   <= aux_ack_nx;
      end
   end

endmodule
